// File: rtl/lsu_pkg.sv
// lsu_pkg
// Shared types and constants for the load/store unit.
//   lsu_state_t     : FSM states of load_store_unit
//   F3_*            : RV32 load/store funct3 width/sign codes
//   lsu_req_t       : request captured at accept
//   is_subword()    : true for byte/half stores, which need read-modify-write
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        RD_WAIT = 3'd2,
        WR      = 3'd3,
        RESP    = 3'd4
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic        read;
        logic        write;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
    } lsu_req_t;

    function automatic logic is_subword(input logic [2:0] funct3);
        return (funct3 == F3_B) || (funct3 == F3_H);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align
// Combinational lane logic for the load/store unit.
// Ports:
//   funct3     in   3   width/sign code of the request
//   addr_lo    in   2   low byte-address bits (byte lane = addr_lo, half lane = addr_lo[1])
//   rdata      in   32  word read from memory
//   wdata      in   32  store data, low byte/half used for B/H
//   load_data  out  32  extracted and sign/zero-extended load result
//   store_data out  32  memory word with the target lane(s) replaced
// Misaligned halfword/word addresses are not checked here; H uses addr_lo[1]
// and W ignores addr_lo entirely.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Select the addressed byte and halfword out of the read word.
    always_comb begin
        lane_byte = rdata[7:0];
        case (addr_lo)
            2'd0: lane_byte = rdata[7:0];
            2'd1: lane_byte = rdata[15:8];
            2'd2: lane_byte = rdata[23:16];
            2'd3: lane_byte = rdata[31:24];
            default: lane_byte = rdata[7:0];
        endcase
        lane_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // Load result: signed codes replicate the lane's top bit, unsigned codes pad with zeros.
    always_comb begin
        load_data = 32'd0;
        case (funct3)
            F3_B:    load_data = {{24{lane_byte[7]}}, lane_byte};
            F3_H:    load_data = {{16{lane_half[15]}}, lane_half};
            F3_W:    load_data = rdata;
            F3_BU:   load_data = {24'd0, lane_byte};
            F3_HU:   load_data = {16'd0, lane_half};
            default: load_data = 32'd0;
        endcase
    end

    // Store merge: keep the untouched lanes of the old word, since memory has no byte strobes.
    always_comb begin
        store_data = rdata;
        case (funct3)
            F3_B: begin
                case (addr_lo)
                    2'd0: store_data = {rdata[31:8], wdata[7:0]};
                    2'd1: store_data = {rdata[31:16], wdata[7:0], rdata[7:0]};
                    2'd2: store_data = {rdata[31:24], wdata[7:0], rdata[15:0]};
                    2'd3: store_data = {wdata[7:0], rdata[23:0]};
                    default: store_data = rdata;
                endcase
            end
            F3_H: begin
                if (addr_lo[1])
                    store_data = {wdata[15:0], rdata[15:0]};
                else
                    store_data = {rdata[31:16], wdata[15:0]};
            end
            F3_W:    store_data = wdata;
            default: store_data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit
// Executes one RV32 load or store at a time against a word-addressed data
// memory with registered read data and no byte strobes. Byte/half stores are
// done as read-modify-write. Completion is reported with a one-cycle pulse.
// Parameters:
//   NUM_WORDS   data memory depth in words; larger word indices are faults
// Configuration macro:
//   MISALIGN_TRAP_EN  when defined, misaligned H/W accesses complete with resp_err
// Ports:
//   clk, n_rst                      clock, async active-low reset
//   req_valid/req_ready             request handshake (accept when both high)
//   req_read/req_write/req_funct3   operation and width code
//   req_addr/req_wdata/req_rd       byte address, store data, destination tag
//   MemRead/MemWr/mem_addr/mem_wdata/mem_rdata   data memory interface
//   resp_valid/resp_data/resp_rd/resp_err        completion to writeback
module load_store_unit #(
    parameter int NUM_WORDS = 32
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        MemRead,
    output logic        MemWr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        resp_err
);

    import lsu_pkg::*;

    localparam logic [31:0] NUM_WORDS_U = 32'(NUM_WORDS);

    lsu_state_t  state;
    lsu_state_t  next_state;
    lsu_req_t    req_q;
    logic [31:0] data_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic        req_err;
    logic        accept;
    logic        active;
    logic [31:0] load_data;
    logic [31:0] store_data;

    assign accept = req_valid && (state == IDLE);

    // Classify the incoming request; any error skips memory entirely.
    always_comb begin
        req_err = 1'b0;
        if ({2'b00, req_addr[31:2]} >= NUM_WORDS_U)
            req_err = 1'b1;
        if (req_read == req_write)
            req_err = 1'b1;
        if (req_read && !(req_funct3 == F3_B || req_funct3 == F3_H || req_funct3 == F3_W ||
                          req_funct3 == F3_BU || req_funct3 == F3_HU))
            req_err = 1'b1;
        if (req_write && !(req_funct3 == F3_B || req_funct3 == F3_H || req_funct3 == F3_W))
            req_err = 1'b1;
`ifdef MISALIGN_TRAP_EN
        if ((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0])
            req_err = 1'b1;
        if (req_funct3 == F3_W && req_addr[1:0] != 2'b00)
            req_err = 1'b1;
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next state: word stores go straight to WR, everything else that touches memory reads first.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_err)
                        next_state = RESP;
                    else if (req_read || is_subword(req_funct3))
                        next_state = RD;
                    else
                        next_state = WR;
                end
            end
            RD:      next_state = RD_WAIT;
            RD_WAIT: next_state = req_q.write ? WR : RESP;
            WR:      next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request capture at accept, then load result or merged store word captured in RD_WAIT.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            req_q   <= '0;
            data_q  <= 32'd0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (accept) begin
            req_q   <= '{read:   req_read,
                         write:  req_write,
                         funct3: req_funct3,
                         addr:   req_addr,
                         wdata:  req_wdata,
                         rd:     req_rd};
            data_q  <= 32'd0;
            wdata_q <= req_wdata;
            err_q   <= req_err;
        end else if (state == RD_WAIT) begin
            if (req_q.read)
                data_q <= load_data;
            else
                wdata_q <= store_data;
        end
    end

    lsu_align u_align (
        .funct3     (req_q.funct3),
        .addr_lo    (req_q.addr[1:0]),
        .rdata      (mem_rdata),
        .wdata      (req_q.wdata),
        .load_data  (load_data),
        .store_data (store_data)
    );

    // Outputs decoded from the registered state; memory and response buses read 0 outside their phases.
    always_comb begin
        active     = (state == RD) || (state == RD_WAIT) || (state == WR);
        req_ready  = (state == IDLE);
        MemRead    = (state == RD);
        MemWr      = (state == WR);
        mem_addr   = active ? {2'b00, req_q.addr[31:2]} : 32'd0;
        mem_wdata  = active ? wdata_q : 32'd0;
        resp_valid = (state == RESP);
        resp_data  = (state == RESP) ? data_q : 32'd0;
        resp_rd    = (state == RESP) ? req_q.rd : 5'd0;
        resp_err   = (state == RESP) ? err_q : 1'b0;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
// Self-checking bench for load_store_unit: a behavioural memory model tracks
// what the data memory should hold and predicts every response, its latency
// and the cycles on which MemRead/MemWr fire. Honours MISALIGN_TRAP_EN.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_read = 1'b0;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [4:0]  req_rd = 5'd0;
    logic        MemRead;
    logic        MemWr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_err;

    int assert_count = 0;
    int fail_count = 0;

    logic [31:0] dmem [0:31];
    logic [31:0] ref_mem [0:31];
    logic        tb_wr_en = 1'b0;
    logic [4:0]  tb_wr_addr = 5'd0;
    logic [31:0] tb_wr_data = 32'd0;

    logic [31:0] last_wword;
    logic [31:0] got_data;
    logic        got_err;

    always #5 clk = ~clk;

    load_store_unit #(.NUM_WORDS(32)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_read   (req_read),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .MemRead    (MemRead),
        .MemWr      (MemWr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_rd    (resp_rd),
        .resp_err   (resp_err)
    );

    // Data memory with registered read; the bench preload port has priority.
    always @(posedge clk) begin
        if (tb_wr_en)
            dmem[tb_wr_addr] <= tb_wr_data;
        else if (MemWr)
            dmem[mem_addr[4:0]] <= mem_wdata;
        if (MemRead)
            mem_rdata <= dmem[mem_addr[4:0]];
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assert_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: predicts the outcome of one request from the ISA rules and updates ref_mem.
    task automatic refModel(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] exp_data, output logic exp_err,
                            output int exp_lat, output logic [7:0] exp_rd_mask,
                            output logic [7:0] exp_wr_mask, output logic [31:0] exp_wword);
        logic [31:0] idx, lane, hl, word, v, old_v, nw;
        logic        legal;
        idx = addr / 4;
        lane = addr % 4;
        hl = (lane / 2) * 2;
        exp_data = 0; exp_err = 0; exp_lat = 1;
        exp_rd_mask = 0; exp_wr_mask = 0; exp_wword = 0;
        if (rd_en)
            legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
        else
            legal = (f3 == 0) || (f3 == 1) || (f3 == 2);
        exp_err = (idx >= 32) || (rd_en == wr_en) || !legal;
`ifdef MISALIGN_TRAP_EN
        if ((f3 == 1 || f3 == 5) && (addr % 2 != 0)) exp_err = 1;
        if (f3 == 2 && lane != 0) exp_err = 1;
`endif
        if (exp_err) return;
        word = ref_mem[idx[4:0]];
        if (rd_en) begin
            exp_lat = 3;
            exp_rd_mask = 8'b0000_0010;
            case (f3)
                3'd0, 3'd4: begin
                    v = (word >> (8 * lane)) % 256;
                    if (f3 == 0 && v >= 128) v = v + 32'hFFFF_FF00;
                end
                3'd1, 3'd5: begin
                    v = (word >> (8 * hl)) % 65536;
                    if (f3 == 1 && v >= 32768) v = v + 32'hFFFF_0000;
                end
                default: v = word;
            endcase
            exp_data = v;
        end else if (f3 == 2) begin
            exp_lat = 2;
            exp_wr_mask = 8'b0000_0010;
            exp_wword = wdata;
            ref_mem[idx[4:0]] = wdata;
        end else begin
            exp_lat = 4;
            exp_rd_mask = 8'b0000_0010;
            exp_wr_mask = 8'b0000_1000;
            if (f3 == 0) begin
                old_v = (word >> (8 * lane)) % 256;
                nw = word - (old_v << (8 * lane)) + ((wdata % 256) << (8 * lane));
            end else begin
                old_v = (word >> (8 * hl)) % 65536;
                nw = word - (old_v << (8 * hl)) + ((wdata % 65536) << (8 * hl));
            end
            exp_wword = nw;
            ref_mem[idx[4:0]] = nw;
        end
    endtask

    // Issue one request, follow it to completion and compare against the model.
    task automatic applyStimulus(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [4:0] tag,
                                 output logic [31:0] out_data, output logic out_err);
        logic [31:0] exp_data, exp_wword, wword;
        logic        exp_err, seen;
        logic [7:0]  exp_rd_mask, exp_wr_mask, rd_mask, wr_mask;
        int          exp_lat, cyc, guard;
        refModel(rd_en, wr_en, f3, addr, wdata, exp_data, exp_err, exp_lat,
                 exp_rd_mask, exp_wr_mask, exp_wword);
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("req_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_read = rd_en; req_write = wr_en; req_funct3 = f3;
        req_addr = addr; req_wdata = wdata; req_rd = tag;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rd_mask = 0; wr_mask = 0; wword = 0; seen = 0; cyc = 1;
        out_data = 32'd0; out_err = 1'b0;
        while (cyc <= 7 && !seen) begin
            if (MemRead || MemWr)
                checkOutput("mem_addr", mem_addr, addr / 4);
            if (MemRead) rd_mask[cyc] = 1'b1;
            if (MemWr) begin
                wr_mask[cyc] = 1'b1;
                wword = mem_wdata;
            end
            if (resp_valid) begin
                seen = 1'b1;
                out_data = resp_data;
                out_err = resp_err;
                checkOutput("resp_data", resp_data, exp_data);
                checkOutput("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
                checkOutput("resp_rd", {27'd0, resp_rd}, {27'd0, tag});
            end else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        checkOutput("resp_seen", {31'd0, seen}, 32'd1);
        checkOutput("latency", cyc, exp_lat);
        checkOutput("memread_cycles", {24'd0, rd_mask}, {24'd0, exp_rd_mask});
        checkOutput("memwr_cycles", {24'd0, wr_mask}, {24'd0, exp_wr_mask});
        if (exp_wr_mask != 0)
            checkOutput("mem_wdata", wword, exp_wword);
        last_wword = wword;
    endtask

    logic [31:0] saved_word;

    initial begin
        // Reset with memory preload.
        n_rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            tb_wr_en = 1'b1;
            tb_wr_addr = 5'(i);
            tb_wr_data = (i == 3) ? 32'h8899_AABB : $urandom;
            ref_mem[i] = tb_wr_data;
        end
        @(negedge clk);
        tb_wr_en = 1'b0;
        checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("rst_memread", {31'd0, MemRead}, 32'd0);
        checkOutput("rst_memwr", {31'd0, MemWr}, 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("rst_resp_data", resp_data, 32'd0);
        checkOutput("rst_resp_err", {31'd0, resp_err}, 32'd0);
        n_rst = 1'b1;

        // Directed cases from known values.
        applyStimulus(1, 0, 3'b000, 32'h0E, 32'd0, 5'd1, got_data, got_err);
        checkOutput("lb_sign", got_data, 32'hFFFF_FF99);
        applyStimulus(1, 0, 3'b100, 32'h0E, 32'd0, 5'd2, got_data, got_err);
        checkOutput("lbu_zero", got_data, 32'h0000_0099);
        applyStimulus(0, 1, 3'b001, 32'h0E, 32'h1234_5678, 5'd3, got_data, got_err);
        checkOutput("sh_merge", last_wword, 32'h5678_AABB);
        checkOutput("sh_resp_data", got_data, 32'd0);
        applyStimulus(1, 0, 3'b010, 32'h0C, 32'd0, 5'd4, got_data, got_err);
        checkOutput("lw_after_sh", got_data, 32'h5678_AABB);
        applyStimulus(0, 1, 3'b010, 32'h10, 32'hDEAD_BEEF, 5'd5, got_data, got_err);
        applyStimulus(1, 0, 3'b010, 32'h10, 32'd0, 5'd6, got_data, got_err);
        checkOutput("lw_after_sw", got_data, 32'hDEAD_BEEF);
        applyStimulus(1, 0, 3'b010, 32'h80, 32'd0, 5'd7, got_data, got_err);
        checkOutput("lw_range_err", {31'd0, got_err}, 32'd1);
        applyStimulus(1, 0, 3'b010, 32'h7C, 32'd0, 5'd8, got_data, got_err);
        checkOutput("lw_last_word_ok", {31'd0, got_err}, 32'd0);
        applyStimulus(1, 0, 3'b001, 32'h05, 32'd0, 5'd9, got_data, got_err);
`ifdef MISALIGN_TRAP_EN
        checkOutput("lh_misalign_err", {31'd0, got_err}, 32'd1);
`else
        checkOutput("lh_misalign_err", {31'd0, got_err}, 32'd0);
`endif
        applyStimulus(1, 1, 3'b010, 32'h08, 32'd0, 5'd10, got_data, got_err);
        applyStimulus(0, 0, 3'b010, 32'h08, 32'd0, 5'd11, got_data, got_err);
        applyStimulus(1, 0, 3'b011, 32'h08, 32'd0, 5'd12, got_data, got_err);
        applyStimulus(0, 1, 3'b100, 32'h08, 32'h55, 5'd13, got_data, got_err);

        // Reset in the middle of a byte store: nothing may reach memory.
        saved_word = ref_mem[5];
        @(negedge clk);
        while (!req_ready) @(negedge clk);
        req_valid = 1'b1; req_read = 1'b0; req_write = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h15; req_wdata = ~saved_word; req_rd = 5'd20;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checkOutput("abort_rd_phase", {31'd0, MemRead}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("abort_wait_addr", mem_addr, 32'd5);
        n_rst = 1'b0;
        #1;
        checkOutput("abort_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("abort_memwr", {31'd0, MemWr}, 32'd0);
        checkOutput("abort_memread", {31'd0, MemRead}, 32'd0);
        checkOutput("abort_mem_addr", mem_addr, 32'd0);
        checkOutput("abort_mem_wdata", mem_wdata, 32'd0);
        checkOutput("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("abort_memwr_hold", {31'd0, MemWr}, 32'd0);
        end
        @(negedge clk);
        n_rst = 1'b1;
        applyStimulus(1, 0, 3'b010, 32'h14, 32'd0, 5'd21, got_data, got_err);
        checkOutput("abort_word_intact", got_data, saved_word);

        // Randomized traffic against the model.
        for (int n = 0; n < 300; n++) begin
            logic        r_rd, r_wr;
            logic [2:0]  r_f3;
            int          kind;
            kind = $urandom_range(0, 19);
            if (kind == 0) begin r_rd = 1; r_wr = 1; end
            else if (kind == 1) begin r_rd = 0; r_wr = 0; end
            else begin r_rd = kind[0]; r_wr = !kind[0]; end
            if ($urandom_range(0, 9) == 0)
                r_f3 = 3'($urandom_range(0, 7));
            else if (r_rd && !r_wr) begin
                case ($urandom_range(0, 4))
                    0: r_f3 = 3'b000;
                    1: r_f3 = 3'b001;
                    2: r_f3 = 3'b010;
                    3: r_f3 = 3'b100;
                    default: r_f3 = 3'b101;
                endcase
            end else
                r_f3 = 3'($urandom_range(0, 2));
            applyStimulus(r_rd, r_wr, r_f3, 32'($urandom_range(0, 139)), $urandom,
                          5'($urandom_range(0, 31)), got_data, got_err);
        end

        // Final sweep: every word read back must match the model.
        for (int i = 0; i < 32; i++)
            applyStimulus(1, 0, 3'b010, 32'(i * 4), 32'd0, 5'(i), got_data, got_err);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
